// File: rtl/key_bounce_gen.sv
// key_bounce_gen: emulates a mechanical push-button.
// Each accepted press request produces one full press cycle on key_o:
// an optional LFSR-noise contact bounce, a stable hold, a release bounce,
// and then a stable released gap before the next request can be taken.
module key_bounce_gen #(
  parameter int          CLK_FREQ_MHZ   = 150,
  parameter int          GLITCH_TIME_NS = 100,
  parameter int          HOLD_TIME_NS   = 1000,
  parameter logic [15:0] LFSR_SEED      = 16'hACE1,
  parameter int          PRESS_CNT_W    = 8
) (
  input  logic                   clk_i,
  input  logic                   srst_i,
  input  logic                   press_stb_i,
  input  logic                   bounce_en_i,
  output logic                   key_o,
  output logic                   ready_o,
  output logic                   done_stb_o,
  output logic [PRESS_CNT_W-1:0] press_cnt_o
);

  // Phase lengths in clock cycles. BOUNCE_CYCLES must be at least 1 and
  // HOLD_CYCLES must exceed BOUNCE_CYCLES+2 so a debouncer sees one press.
  localparam int BOUNCE_CYCLES = GLITCH_TIME_NS * CLK_FREQ_MHZ / 1000;
  localparam int HOLD_CYCLES   = HOLD_TIME_NS * CLK_FREQ_MHZ / 1000;
  localparam int MAX_CYCLES    = (BOUNCE_CYCLES > HOLD_CYCLES) ? BOUNCE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W         = $clog2(MAX_CYCLES + 1);

  localparam logic [CNT_W-1:0] BOUNCE_LOAD = CNT_W'(BOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_TWO     = CNT_W'(2);

  // A one-cycle bounce window has no room for noise: its only cycle is
  // also its last one, which is forced to the settled level.
  localparam bit BOUNCE_HAS_NOISE = (BOUNCE_CYCLES > 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRESS_BOUNCE,
    S_HOLD,
    S_RELEASE_BOUNCE,
    S_GAP
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [15:0]            lfsr_q;
  logic [15:0]            lfsr_d;
  logic                   bounce_en_q;
  logic                   key_q;
  logic                   ready_q;
  logic                   done_stb_q;
  logic [PRESS_CNT_W-1:0] press_cnt_q;

  // Fibonacci LFSR for x^16+x^14+x^13+x^11+1, shifting toward bit 0.
  always_comb begin
    lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
  end

  // Press-cycle FSM; the counter is loaded on each state entry and the
  // state advances when it reads 1. key_o for the upcoming cycle is decided
  // here from the pre-shift LFSR bit, so every output is a flop.
  always_ff @(posedge clk_i) begin
    if (srst_i) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      lfsr_q      <= LFSR_SEED;
      bounce_en_q <= 1'b0;
      key_q       <= 1'b0;
      ready_q     <= 1'b1;
      done_stb_q  <= 1'b0;
      press_cnt_q <= '0;
    end else begin
      lfsr_q     <= lfsr_d;
      done_stb_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          key_q <= 1'b0;
          if (press_stb_i) begin
            bounce_en_q <= bounce_en_i;
            state_q     <= S_PRESS_BOUNCE;
            cnt_q       <= BOUNCE_LOAD;
            ready_q     <= 1'b0;
            key_q       <= (bounce_en_i && BOUNCE_HAS_NOISE) ? lfsr_q[0] : 1'b1;
          end
        end
        S_PRESS_BOUNCE: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= S_HOLD;
            cnt_q   <= HOLD_LOAD;
            key_q   <= 1'b1;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            // The cycle entered with count 1 is the last bounce cycle: settle high.
            key_q <= (bounce_en_q && (cnt_q != CNT_TWO)) ? lfsr_q[0] : 1'b1;
          end
        end
        S_HOLD: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= S_RELEASE_BOUNCE;
            cnt_q   <= BOUNCE_LOAD;
            key_q   <= (bounce_en_q && BOUNCE_HAS_NOISE) ? lfsr_q[0] : 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            key_q <= 1'b1;
          end
        end
        S_RELEASE_BOUNCE: begin
          if (cnt_q == CNT_ONE) begin
            state_q <= S_GAP;
            cnt_q   <= HOLD_LOAD;
            key_q   <= 1'b0;
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
            // Last release-bounce cycle settles low.
            key_q <= (bounce_en_q && (cnt_q != CNT_TWO)) ? lfsr_q[0] : 1'b0;
          end
        end
        S_GAP: begin
          key_q <= 1'b0;
          if (cnt_q == CNT_ONE) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ready_q     <= 1'b1;
            done_stb_q  <= 1'b1;
            press_cnt_q <= press_cnt_q + PRESS_CNT_W'(1);
          end else begin
            cnt_q <= cnt_q - CNT_ONE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          key_q   <= 1'b0;
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign key_o       = key_q;
  assign ready_o     = ready_q;
  assign done_stb_o  = done_stb_q;
  assign press_cnt_o = press_cnt_q;

endmodule
